ram2_arbiter: RTL
=================

// Module: ram2_arbiter
// PURPOSE
//  Sole owner of the shared RAM2 SRAM. Arbitrates between instruction fetch (IF) and data access (DM).
//  Sequences SRAM timing (read, write setup/pulse/hold) and stalls IF while DM holds the RAM.
//  Sits between the pipeline's IF/MEM stages and the board SRAM pins.
// PARAMETERS
//  ADDR_W      18  SRAM address width; 16-bit requester address zero-extended (ADDR_W >= 16)
//  DATA_W      16  SRAM data width
//  READ_CYCLES 1   cycles spent in RD with oe_n low (1..4)
// PORTS
//  clk        in    1        system clock, rising edge
//  rst        in    1        asynchronous, active-low reset
//  if_req     in    1        fetch request, held until if_ready
//  if_addr    in    16       fetch address
//  if_data    out   DATA_W   last fetched word, valid when if_ready
//  if_ready   out   1        one-cycle pulse: fetch complete
//  stall_if   out   1        if_req & ~if_ready (combinational)
//  dm_req     in    1        data request, held until dm_ready
//  dm_wr      in    1        1 = write, 0 = read; sampled at grant
//  dm_addr    in    16       data address
//  dm_wdata   in    DATA_W   write data, sampled at grant
//  dm_rdata   out   DATA_W   last read word, valid when dm_ready
//  dm_ready   out   1        one-cycle pulse: data access complete
//  ram_addr   out   ADDR_W   SRAM address (registered)
//  ram_data   inout DATA_W   SRAM data bus; Z unless writing
//  ram_ce_n   out   1        SRAM chip enable, active low
//  ram_oe_n   out   1        SRAM output enable, active low
//  ram_we_n   out   1        SRAM write enable, active low
//  state_o    out   3        FSM state, debug
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ce_n=oe_n=we_n=1, ram_data=Z, ram_addr=0.
//   Also at reset: if_ready=dm_ready=0, if_data=dm_rdata=0, grant/fair flags cleared.
//  States: IDLE=0, RD=1, WS=2, WP=3, WH=4. All SRAM controls are registered.
//  IDLE: if dm_req -> grant DM; else if if_req -> grant IF; else stay. Latch owner, addr, wdata.
//   Read -> RD. Write (DM only) -> WS.
//  RD: ce_n=0, oe_n=0, we_n=1, bus Z; held for READ_CYCLES cycles.
//   On exit edge: capture ram_data into owner's rdata reg, pulse owner's ready, -> IDLE.
//  WS: ce_n=0, oe_n=1, we_n=1, bus driven with wdata. Lasts 1 cycle.
//  WP: we_n=0, bus driven. Exactly 1 cycle.
//  WH: we_n=1, bus still driven (hold). Exit edge: pulse dm_ready, release bus, ce_n=1, -> IDLE.
//  Latency from grant edge: read ready after 1+READ_CYCLES cycles; write ready after 4 cycles.
//  The ready cycle is an IDLE cycle; req high during it is a NEW request (back-to-back allowed).
//   Requesters drop or change req in their ready cycle.
//  Requests arriving outside IDLE wait; the latched addr/wdata are unaffected by input changes.
//  Simultaneous IF/DM in IDLE: DM wins (see CONFIGURATION).
//  IF never writes; if_data/dm_rdata hold their value until the next read by the same owner.
//  Reset mid-access (incl. WP): controls return to 1 immediately, bus Z. Access aborted, no ready.
//  Upper ADDR_W-16 address bits are always 0.
// CONFIGURATION
//  RAM2_FAIR_EN defined: alternating priority. After a DM grant, a simultaneous IF+DM request goes to IF.
//   After an IF grant, it goes to DM.
//  RAM2_FAIR_EN undefined: strict DM priority; IF may starve while dm_req stays high.
// TESTING (READ_CYCLES=1; SRAM behavioural model)
//  1 rst=0 mid-run -> ce_n/oe_n/we_n=1, ram_data=Z, state_o=0, readies 0.
//  2 if_req, if_addr=0x0001, mem[1]=0x1234 -> oe_n low 1 cycle; if_ready 2 cycles after grant.
//   Then if_data=0x1234, stall_if high until then.
//  3 dm write addr=3 data=3 -> WS,WP,WH; we_n low exactly 1 cycle with bus=0x0003 stable around it.
//   dm_ready 4 cycles after grant; bus Z after.
//  4 Same-cycle if_req(addr 2) + dm read(addr 3) -> DM served first (dm_rdata=0x0003).
//   Then IF; stall_if high throughout.
//  5 rst=0 while in WP -> we_n=1 same cycle, no dm_ready; after release, mem[addr] unchanged or complete.
//  6 RAM2_FAIR_EN, if_req and dm_req held high 6 grants -> owners alternate DM,IF,DM,IF...
//   Undefined: DM only.

Source files
------------

// File: rtl/ram2_arbiter.sv
// RAM2 SRAM owner: arbitrates IF fetch vs DM data access and sequences SRAM timing.
// Optional alternating IF/DM priority is enabled by defining RAM2_FAIR_EN.
module ram2_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int READ_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ready,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [15:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WS   = 3'd2,
    WP   = 3'd3,
    WH   = 3'd4
  } state_t;

  localparam logic [1:0] RD_LAST = 2'(READ_CYCLES - 1);

  state_t            state;
  logic              owner_dm;
  logic              drive;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        rd_cnt;
  logic              grant_dm;
  logic              grant_if;
`ifdef RAM2_FAIR_EN
  logic              last_dm;
`endif

  assign ram_data = drive ? wdata_q : {DATA_W{1'bz}};
  assign stall_if = if_req & ~if_ready;
  assign state_o  = state;

  // Pick the requester that wins the RAM when the FSM is idle
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
`ifdef RAM2_FAIR_EN
    if (dm_req && if_req) begin
      grant_dm = ~last_dm;
      grant_if = last_dm;
    end else begin
      grant_dm = dm_req;
      grant_if = if_req;
    end
`else
    grant_dm = dm_req;
    grant_if = if_req & ~dm_req;
`endif
  end

  // Access sequencer with registered SRAM controls and ready pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      drive    <= 1'b0;
      wdata_q  <= '0;
      rd_cnt   <= '0;
      ram_addr <= '0;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_data  <= '0;
      dm_rdata <= '0;
`ifdef RAM2_FAIR_EN
      last_dm  <= 1'b0;
`endif
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            owner_dm <= grant_dm;
            ram_addr <= ADDR_W'(grant_dm ? dm_addr : if_addr);
            ram_ce_n <= 1'b0;
            rd_cnt   <= '0;
`ifdef RAM2_FAIR_EN
            last_dm  <= grant_dm;
`endif
            if (grant_dm && dm_wr) begin
              wdata_q <= dm_wdata;
              drive   <= 1'b1;
              state   <= WS;
            end else begin
              ram_oe_n <= 1'b0;
              state    <= RD;
            end
          end
        end
        RD: begin
          if (rd_cnt == RD_LAST) begin
            if (owner_dm) begin
              dm_rdata <= ram_data;
              dm_ready <= 1'b1;
            end else begin
              if_data  <= ram_data;
              if_ready <= 1'b1;
            end
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            state    <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        WS: begin
          ram_we_n <= 1'b0;
          state    <= WP;
        end
        WP: begin
          ram_we_n <= 1'b1;
          state    <= WH;
        end
        WH: begin
          dm_ready <= 1'b1;
          drive    <= 1'b0;
          ram_ce_n <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
